sd_adc_decim: RTL and testbench

- 1-bit sigma-delta ADC receiver, the inverse of the board's 1-bit DAC path.
- An external comparator, with its RC feedback driven by fb_out, produces a density-modulated bitstream on cmp_in.
- The block synchronizes the bitstream, closes the modulator loop, and decimates it with a 2nd-order CIC filter into OUT_W-bit unsigned samples.
- Samples go out on a valid/ready handshake to the audio/tape logic in the clk28 domain.

---
 rtl/sd_pkg.sv | 15 +
 rtl/cic2_decim.sv | 52 +++++
 rtl/sd_adc_decim.sv | 109 ++++++++++
 tb/tb_sd_adc_decim.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared types and sizing helpers for the sigma-delta ADC receiver.
// The CIC width gives DECIM^2 headroom plus one bit, so full scale is representable.
package sd_pkg;

   typedef enum logic [1:0] {
      WARM0 = 2'd0,
      WARM1 = 2'd1,
      RUN   = 2'd2
   } cic_state_t;

   function automatic int cic_width(input int decim);
      return 2 * $clog2(decim) + 1;
   endfunction

endpackage

// File: rtl/cic2_decim.sv
// Second-order CIC decimator: integrators, decimation counter and comb stage.
// o_c2 is combinational and valid in the cycle where o_tick is high.
module cic2_decim
   import sd_pkg::*;
#(
   parameter int DECIM = 256,
   parameter int W     = cic_width(DECIM)
) (
   input  logic         clk28,
   input  logic         rst,
   input  logic         en,
   input  logic         i_s,
   output logic [W-1:0] o_c2,
   output logic         o_tick
);

   localparam int CNT_W = $clog2(DECIM);

   logic [CNT_W-1:0] r_cnt;
   logic [W-1:0]     r_i1;
   logic [W-1:0]     r_i2;
   logic [W-1:0]     r_d1;
   logic [W-1:0]     r_d2;
   logic [W-1:0]     w_c1;

   assign o_tick = en && (r_cnt == CNT_W'(DECIM - 1));

   // Integrators wrap modulo 2^W; the comb differences undo the wrap exactly.
   assign w_c1 = r_i2 - r_d1;
   assign o_c2 = w_c1 - r_d2;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of its neighbours, matching the hardware.
   always_ff @(posedge clk28) begin
      if (rst) begin
         r_cnt <= '0;
         r_i1  <= '0;
         r_i2  <= '0;
         r_d1  <= '0;
         r_d2  <= '0;
      end else if (en) begin
         r_cnt <= r_cnt + 1'b1;
         r_i1  <= r_i1 + W'(i_s);
         r_i2  <= r_i2 + r_i1;
         if (o_tick) begin
            r_d1 <= r_i2;
            r_d2 <= w_c1;
         end
      end
   end

endmodule

// File: rtl/sd_adc_decim.sv
// 1-bit sigma-delta ADC receiver: input synchronizer, loop feedback, CIC
// decimation with warm-up discard, and a valid/ready sample register.
module sd_adc_decim
   import sd_pkg::*;
#(
   parameter int DECIM = 256,
   parameter int OUT_W = 8
) (
   input  logic             clk28,
   input  logic             rst,
   input  logic             en,
   input  logic             cmp_in,
   output logic             fb_out,
   output logic [OUT_W-1:0] sample,
   output logic             sample_valid,
   input  logic             sample_ready,
   output logic             overrun
);

   localparam int W     = cic_width(DECIM);
   localparam int R_W   = 2 * $clog2(DECIM);
   localparam int SHIFT = R_W - OUT_W;
   localparam logic [W-1:0] FULL_SCALE = {1'b1, {(W - 1){1'b0}}};

   logic [1:0]       r_sync;
   logic             r_fb;
   logic [OUT_W-1:0] r_sample;
   logic             r_valid;
   logic             r_overrun;
   cic_state_t       r_state;
   cic_state_t       w_state_nxt;
   logic             w_s;
   logic             w_tick;
   logic             w_publish;
   logic [W-1:0]     w_c2;
   logic [R_W-1:0]   w_r;
   logic [OUT_W-1:0] w_sample;

   assign w_s = r_sync[1];

   cic2_decim #(
      .DECIM (DECIM),
      .W     (W)
   ) u_cic (
      .clk28  (clk28),
      .rst    (rst),
      .en     (en),
      .i_s    (w_s),
      .o_c2   (w_c2),
      .o_tick (w_tick)
   );

   // A constant-1 input yields exactly DECIM^2, one past the R_W-bit range.
   assign w_r      = (w_c2 == FULL_SCALE) ? '1 : w_c2[R_W-1:0];
   assign w_sample = OUT_W'(w_r >> SHIFT);

   // The feedback path ignores en so the external modulator loop stays closed.
   always_ff @(posedge clk28) begin
      if (rst) begin
         r_sync <= '0;
         r_fb   <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], cmp_in};
         r_fb   <= w_s;
      end
   end

   always_ff @(posedge clk28) begin
      if (rst) r_state <= WARM0;
      else     r_state <= w_state_nxt;
   end

   // NOTE: every combinational output gets a default first, so no path
   // through the block can leave it unassigned and infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      if (w_tick) begin
         case (r_state)
            WARM0:   w_state_nxt = WARM1;
            WARM1:   w_state_nxt = RUN;
            default: w_state_nxt = RUN;
         endcase
      end
   end

   always_comb begin
      w_publish = w_tick && (r_state == RUN);
   end

   always_ff @(posedge clk28) begin
      if (rst) begin
         r_sample  <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else if (w_publish) begin
         r_sample <= w_sample;
         r_valid  <= 1'b1;
         if (r_valid && !sample_ready) r_overrun <= 1'b1;
      end else if (r_valid && sample_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign fb_out       = r_fb;
   assign sample       = r_sample;
   assign sample_valid = r_valid;
   assign overrun      = r_overrun;

endmodule

// File: tb/tb_sd_adc_decim.sv
// Directed bench for sd_adc_decim at DECIM=256, OUT_W=8: reset, saturation,
// zero input, half-scale toggle, overrun, coincident publish, en gap, reset.
`timescale 1ns/1ps
module tb_sd_adc_decim;

   logic       clk28;
   logic       rst;
   logic       en;
   logic       cmp_in;
   logic       fb_out;
   logic [7:0] sample;
   logic       sample_valid;
   logic       sample_ready;
   logic       overrun;

   int         n_checks;
   int         n_errors;
   int         n;
   logic       toggle_on;
   logic [3:0] hist;

   sd_adc_decim #(
      .DECIM (256),
      .OUT_W (8)
   ) dut (
      .clk28        (clk28),
      .rst          (rst),
      .en           (en),
      .cmp_in       (cmp_in),
      .fb_out       (fb_out),
      .sample       (sample),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .overrun      (overrun)
   );

   initial clk28 = 1'b0;
   always #18 clk28 = ~clk28;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock; inputs change and outputs are read 1 ns after the edge.
   task automatic step();
      @(posedge clk28);
      #1;
      if (toggle_on) cmp_in = ~cmp_in;
      hist = {hist[2:0], cmp_in};
   endtask

   // Steps at least once, then until sample_valid, bounded by 2000 cycles.
   task automatic wait_valid(output int cycles);
      cycles = 0;
      do begin
         step();
         cycles++;
      end while (!sample_valid && cycles < 2000);
   endtask

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      rst          = 1'b1;
      en           = 1'b1;
      cmp_in       = 1'b1;
      sample_ready = 1'b1;
      toggle_on    = 1'b0;
      hist         = '0;

      repeat (3) step();
      check("rst_fb_out", fb_out, 1'b0);
      check("rst_sample", sample, 8'd0);
      check("rst_valid", sample_valid, 1'b0);
      check("rst_overrun", overrun, 1'b0);

      // Full-scale input saturates to 255 every frame
      rst = 1'b0;
      wait_valid(n);
      check("t1_first_latency_ok", (n >= 767 && n <= 771), 1'b1);
      check("t1_first_sample", sample, 8'd255);
      check("t1_fb_out", fb_out, 1'b1);
      for (int k = 0; k < 2; k++) begin
         wait_valid(n);
         check("t1_period", n, 256);
         check("t1_sample", sample, 8'd255);
      end

      // Zero input
      rst = 1'b1; cmp_in = 1'b0;
      step();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         wait_valid(n);
         check("t2_valid", sample_valid, 1'b1);
         check("t2_sample", sample, 8'd0);
         check("t2_fb_out", fb_out, 1'b0);
      end

      // Alternating input is exactly half scale
      rst = 1'b1; toggle_on = 1'b1;
      step();
      rst = 1'b0;
      wait_valid(n);
      check("t3_first_near_half", (sample >= 8'd127 && sample <= 8'd129), 1'b1);
      for (int k = 0; k < 2; k++) begin
         wait_valid(n);
         check("t3_sample", sample, 8'd128);
      end
      for (int k = 0; k < 4; k++) begin
         step();
         check("t3_fb_delay3", fb_out, hist[3]);
      end
      toggle_on = 1'b0;

      // Overrun when a publish lands on an unconsumed sample
      rst = 1'b1; cmp_in = 1'b1; sample_ready = 1'b0;
      step();
      rst = 1'b0;
      wait_valid(n);
      check("t4_first_sample", sample, 8'd255);
      check("t4_no_overrun_yet", overrun, 1'b0);
      repeat (256) step();
      check("t4_overrun", overrun, 1'b1);
      check("t4_valid", sample_valid, 1'b1);
      check("t4_sample", sample, 8'd255);
      sample_ready = 1'b1;
      step();
      sample_ready = 1'b0;
      check("t4_consumed", sample_valid, 1'b0);
      check("t4_overrun_sticky", overrun, 1'b1);

      // Publish coincident with consumption: 0 then a ramp-up frame of 124
      rst = 1'b1; cmp_in = 1'b0;
      step();
      rst = 1'b0;
      wait_valid(n);
      check("t5_first_sample", sample, 8'd0);
      cmp_in = 1'b1;
      repeat (255) step();
      check("t5_held_valid", sample_valid, 1'b1);
      check("t5_held_sample", sample, 8'd0);
      sample_ready = 1'b1;
      step();
      check("t5_new_sample", sample, 8'd124);
      check("t5_valid", sample_valid, 1'b1);
      check("t5_no_overrun", overrun, 1'b0);

      // en low for 100 cycles delays the next publish by 100 cycles
      rst = 1'b1; sample_ready = 1'b0;
      step();
      rst = 1'b0;
      wait_valid(n);
      repeat (100) step();
      en = 1'b0;
      repeat (50) step();
      sample_ready = 1'b1;
      step();
      check("t6_consume_while_disabled", sample_valid, 1'b0);
      check("t6_fb_while_disabled", fb_out, 1'b1);
      sample_ready = 1'b0;
      repeat (49) step();
      en = 1'b1;
      wait_valid(n);
      check("t6_delayed_publish", n, 156);
      check("t6_sample", sample, 8'd255);
      check("t6_no_overrun", overrun, 1'b0);

      // Reset mid-frame restarts the warm-up
      repeat (50) step();
      rst = 1'b1;
      step();
      check("t6_rst_fb_out", fb_out, 1'b0);
      check("t6_rst_sample", sample, 8'd0);
      check("t6_rst_valid", sample_valid, 1'b0);
      check("t6_rst_overrun", overrun, 1'b0);
      rst = 1'b0;
      wait_valid(n);
      check("t6_restart_latency_ok", (n >= 767 && n <= 771), 1'b1);
      check("t6_restart_sample", sample, 8'd255);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
